// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receive engine.
//
// Synchronises the asynchronous rx pin, qualifies the start bit at its
// midpoint, samples 8 data bits LSB-first at mid-bit, checks the stop bit
// and presents the byte on data_rx with a sticky rcv flag.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   rcv_clr    single-cycle acknowledge from the processor side
//   data_rx    last correctly framed byte
//   rcv        sticky "new byte available"
//   frame_err  1-cycle pulse when the stop bit is sampled low
//   overrun    sticky "a byte completed while rcv was still set"
//   busy       high in every state except IDLE
//
// Handshake: rcv is set by a good stop bit and stays set until the cycle
// after rcv_clr is seen high. rcv_clr also clears overrun. If rcv_clr and a
// good stop bit land on the same edge, the set wins: rcv stays 1 and
// overrun is not raised.
//
// All outputs come straight from flops.

module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rcv_clr,
  output logic [7:0] data_rx,
  output logic       rcv,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Synchroniser: preset to 1 so reset looks like an idle line.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  // Datapath registers and their next values.
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_d;
  logic              rcv_d, ferr_d, ovr_d, busy_d;
  // Set after a framing error: the line must be seen high again before a
  // new start bit is accepted, so a line stuck low cannot retrigger.
  logic              wait_high_q, wait_high_d;

  logic baud_half, baud_last;

  assign baud_half = (baud_q == BAUD_HALF);
  assign baud_last = (baud_q == BAUD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s && !wait_high_q) state_d = START;
      START: if (baud_half) state_d = rx_s ? IDLE : DATA;
      DATA:  if (baud_last && (bit_q == 3'd7)) state_d = STOP;
      STOP:  if (baud_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_rx;
    rcv_d       = rcv;
    ovr_d       = overrun;
    ferr_d      = 1'b0;
    wait_high_d = wait_high_q;

    // Acknowledge first so a completing frame below can override it.
    if (rcv_clr) begin
      rcv_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (rx_s) wait_high_d = 1'b0;
      end
      START: begin
        bit_d  = '0;
        // Moving to DATA (or back to IDLE) restarts the bit period here,
        // which places every later sample at mid-bit.
        baud_d = baud_half ? '0 : baud_q + 1'b1;
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = '0;
          if (rx_s) begin
            data_d = shift_q;
            rcv_d  = 1'b1;
            if (rcv && !rcv_clr) ovr_d = 1'b1;
          end else begin
            ferr_d      = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d = '0;
        bit_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_rx     <= '0;
      rcv         <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_rx     <= data_d;
      rcv         <= rcv_d;
      frame_err   <= ferr_d;
      overrun     <= ovr_d;
      busy        <= busy_d;
      wait_high_q <= wait_high_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench for uart_rx_core at 16 clk/bit.
// Inputs change 1 ns after the rising edge; the monitor samples on the
// falling edge and direct checks run 1 ns after the rising edge.

module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int HALF = (CPB - 1) / 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rcv_clr;
  logic [7:0] data_rx;
  logic       rcv;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rcv_clr   (rcv_clr),
    .data_rx   (data_rx),
    .rcv       (rcv),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic       rcv_prev    = 1'b0;
  logic [7:0] data_prev   = 8'h00;
  logic       ferr_prev   = 1'b0;
  int         ferr_pulses = 0;
  int         ferr_cycles = 0;
  int         rcv_rise_cyc = -1;
  logic       busy_seen   = 1'b0;

  // A delivered byte is either a rising rcv or a data change while rcv holds.
  always @(negedge clk) begin
    if (!rst) begin
      if (rcv && (!rcv_prev || (data_rx != data_prev))) begin
        if (!rcv_prev) rcv_rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got byte 0x%0h, expected none", data_rx);
        end else begin
          exp_byte = exp_q.pop_front();
          check("sb_data", data_rx, exp_byte);
        end
      end
      if (frame_err) ferr_cycles++;
      if (frame_err && !ferr_prev) ferr_pulses++;
      if (busy) busy_seen = 1'b1;
    end
    rcv_prev  = rcv;
    data_prev = data_rx;
    ferr_prev = frame_err;
  end

  // ---------------- driver tasks ----------------
  int frame_start_cyc;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    frame_start_cyc = cyc;
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(CPB);
    end
    rx = stop_bit;
    step(CPB);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic pulse_clr();
    rcv_clr = 1'b1;
    step(1);
    rcv_clr = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic [7:0] exp_data;
    logic       exp_rcv;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  int   f0, c0, off;
  logic idle_bad;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[2] = '{8'h3C, 1'b0, 8'hFF, 1'b0, 1};
    vecs[3] = '{8'h96, 1'b1, 8'h96, 1'b1, 0};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b1, 0};
    vecs[6] = '{8'h5A, 1'b0, 8'h80, 1'b0, 1};
    vecs[7] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 0};

    // Reset and idle.
    rst     = 1'b1;
    rx      = 1'b1;
    rcv_clr = 1'b0;
    step(3);
    rst = 1'b0;
    check("rst_data_rx",   data_rx,   8'h00);
    check("rst_rcv",       rcv,       1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun",   overrun,   1'b0);
    check("rst_busy",      busy,      1'b0);
    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (data_rx != 8'h00 || rcv || frame_err || overrun || busy) idle_bad = 1'b1;
    end
    check("idle_quiet", idle_bad, 1'b0);

    // Single byte with latency and acknowledge.
    rcv_rise_cyc = -1;
    send_good(8'hA5);
    off = rcv_rise_cyc - frame_start_cyc;
    check("single_rcv_latency_in_window",
          (off >= SYNC + 1 + HALF + 9 * CPB) && (off <= SYNC + 2 + HALF + 9 * CPB), 1'b1);
    check("single_data",  data_rx, 8'hA5);
    check("single_rcv",   rcv,     1'b1);
    check("single_busy",  busy,    1'b0);
    pulse_clr();
    check("single_clr_rcv", rcv, 1'b0);

    // Glitch rejection: 5 low cycles.
    f0 = ferr_pulses;
    rx = 1'b0;
    step(2);
    check("glitch_busy_pre", busy, 1'b0);
    step(1);
    check("glitch_busy_rise", busy, 1'b1);
    step(2);
    rx = 1'b1;
    step(20);
    check("glitch_busy_end", busy, 1'b0);
    check("glitch_rcv",      rcv,  1'b0);
    check("glitch_ferr",     ferr_pulses - f0, 0);
    check("glitch_data",     data_rx, 8'hA5);

    // Framing error, line held low afterwards, then recovery.
    f0 = ferr_pulses;
    c0 = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    busy_seen = 1'b0;
    step(3 * CPB);
    check("ferr_no_retrigger", busy_seen, 1'b0);
    check("ferr_pulses", ferr_pulses - f0, 1);
    check("ferr_width",  ferr_cycles - c0, 1);
    check("ferr_rcv",    rcv,     1'b0);
    check("ferr_data",   data_rx, 8'hA5);
    rx = 1'b1;
    step(4);
    send_good(8'h5A);
    step(4);
    check("ferr_next_data", data_rx, 8'h5A);
    check("ferr_next_rcv",  rcv,     1'b1);
    pulse_clr();

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_pulses;
      c0 = ferr_cycles;
      if (vecs[i].stop_ok) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_ok);
      rx = 1'b1;
      step(4);
      check($sformatf("vec%0d_data", i),   data_rx, vecs[i].exp_data);
      check($sformatf("vec%0d_rcv", i),    rcv,     vecs[i].exp_rcv);
      check($sformatf("vec%0d_ferr", i),   ferr_pulses - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ferr_w", i), ferr_cycles - c0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i),    overrun, 1'b0);
      check($sformatf("vec%0d_busy", i),   busy,    1'b0);
      pulse_clr();
      check($sformatf("vec%0d_clr", i),    rcv,     1'b0);
    end

    // Overrun: two frames back-to-back without acknowledge.
    send_good(8'h11);
    send_good(8'h22);
    step(4);
    check("ovr_data",    data_rx, 8'h22);
    check("ovr_rcv",     rcv,     1'b1);
    check("ovr_overrun", overrun, 1'b1);
    pulse_clr();
    check("ovr_clr_rcv",     rcv,     1'b0);
    check("ovr_clr_overrun", overrun, 1'b0);

    // Acknowledge landing on the second stop-bit sample edge.
    send_good(8'h11);
    fork
      send_good(8'h22);
      begin
        step(SYNC + 1 + HALF + 9 * CPB);
        rcv_clr = 1'b1;
        step(1);
        rcv_clr = 1'b0;
      end
    join
    step(4);
    check("simul_data",    data_rx, 8'h22);
    check("simul_rcv",     rcv,     1'b1);
    check("simul_overrun", overrun, 1'b0);
    pulse_clr();

    // Reset during data bit 4 of 0xFF.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        step(5 * CPB + 4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
    join
    step(4);
    check("rstmid_rcv",  rcv,     1'b0);
    check("rstmid_data", data_rx, 8'h00);
    check("rstmid_busy", busy,    1'b0);
    send_good(8'h81);
    step(4);
    check("rstmid_next_data", data_rx, 8'h81);
    check("rstmid_next_rcv",  rcv,     1'b1);

    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
